// File: rtl/wb_burst_master_if.sv
`default_nettype none
// ============================================================================
// wb_burst_master_if : Wishbone B3 registered-feedback burst bus bundle
// Revision: 1.0
// ============================================================================
interface wb_burst_master_if #(
   parameter int DW = 32,
   parameter int AW = 32
);
   logic [AW-1:0] wb_adr_o;
   logic [DW-1:0] wb_dat_o;
   logic [3:0]    wb_sel_o;
   logic          wb_we_o;
   logic [2:0]    wb_cti_o;
   logic [1:0]    wb_bte_o;
   logic          wb_cyc_o;
   logic          wb_stb_o;
   logic          wb_ack_i;
   logic          wb_err_i;
   logic [DW-1:0] wb_dat_i;

   modport master (
      output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cti_o, wb_bte_o,
             wb_cyc_o, wb_stb_o,
      input  wb_ack_i, wb_err_i, wb_dat_i
   );

   modport slave (
      input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cti_o, wb_bte_o,
             wb_cyc_o, wb_stb_o,
      output wb_ack_i, wb_err_i, wb_dat_i
   );
endinterface
`default_nettype wire

// File: rtl/wb_burst_master.sv
`default_nettype none
// ============================================================================
// wb_burst_master : one command -> one Wishbone B3 linear/wrapping burst
// Optional strobe timeout abort: WB_BURST_MASTER_TIMEOUT_EN
// Revision: 1.0
// ============================================================================
module wb_burst_master #(
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int MAX_LEN = 16,
   parameter int LW      = $clog2(MAX_LEN + 1),
   parameter int TIMEOUT = 255
) (
   input  wire             wb_clk_i,
   input  wire             wb_rst_ni,
   input  wire             cmd_valid_i,
   output logic            cmd_ready_o,
   input  wire [AW-1:0]    cmd_adr_i,
   input  wire             cmd_we_i,
   input  wire [LW-1:0]    cmd_len_i,
   input  wire [1:0]       cmd_bte_i,
   input  wire [DW-1:0]    wdat_i,
   input  wire             wdat_valid_i,
   output logic            wdat_ready_o,
   output logic [DW-1:0]   rdat_o,
   output logic            rdat_valid_o,
   output logic            done_o,
   output logic            err_o,
   wb_burst_master_if.master wb
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2} state_e;

   localparam logic [LW-1:0] c_max_len = LW'(MAX_LEN);

   state_e          state_q;
   logic [AW-1:0]   adr_q, adr_d;
   logic [DW-1:0]   dat_q, rdat_q;
   logic [LW-1:0]   len_q, acked_q, loaded_q, len_d;
   logic [2:0]      cti_q;
   logic [1:0]      bte_q;
   logic            we_q, cyc_q, stb_q, rdat_valid_q, done_q, err_q;
   logic [AW-1:0]   w_wrap_mask;
   logic            w_ack, w_abort, w_last, w_wr_hs, w_timeout;

   assign len_d   = (cmd_len_i > c_max_len) ? c_max_len : cmd_len_i;
   assign w_ack   = stb_q & wb.wb_ack_i & ~wb.wb_err_i;
   assign w_abort = stb_q & (wb.wb_err_i | w_timeout);
   assign w_last  = (acked_q == (len_q - LW'(1)));
   assign w_wr_hs = wdat_ready_o & wdat_valid_i;

   assign cmd_ready_o  = (state_q == S_IDLE);
   assign wdat_ready_o = (state_q == S_WR) & (~stb_q | w_ack) & (loaded_q < len_q);

   // Wrapping bursts only advance the low log2(N*4) address bits.
   always_comb begin
      w_wrap_mask = '1;
      case (bte_q)
         2'b01:   w_wrap_mask = AW'(8'h0F);
         2'b10:   w_wrap_mask = AW'(8'h1F);
         2'b11:   w_wrap_mask = AW'(8'h3F);
         default: w_wrap_mask = '1;
      endcase
      adr_d = (adr_q & ~w_wrap_mask) | ((adr_q + AW'(4)) & w_wrap_mask);
   end

`ifdef WB_BURST_MASTER_TIMEOUT_EN
   localparam int c_to_w = $clog2(TIMEOUT + 1);

   logic [c_to_w-1:0] to_cnt_q;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         to_cnt_q <= '0;
      end else if (!stb_q || wb.wb_ack_i || wb.wb_err_i) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_q + c_to_w'(1);
      end
   end

   assign w_timeout = stb_q & ~wb.wb_ack_i & ~wb.wb_err_i &
                      (to_cnt_q == c_to_w'(TIMEOUT - 1));
`else
   // Without the timeout feature the master never gives up on a strobe.
   assign w_timeout = (TIMEOUT < 0);
`endif

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q      <= S_IDLE;
         adr_q        <= '0;
         dat_q        <= '0;
         rdat_q       <= '0;
         len_q        <= '0;
         acked_q      <= '0;
         loaded_q     <= '0;
         cti_q        <= 3'b000;
         bte_q        <= 2'b00;
         we_q         <= 1'b0;
         cyc_q        <= 1'b0;
         stb_q        <= 1'b0;
         rdat_valid_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         rdat_valid_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid_i) begin
                  adr_q    <= cmd_adr_i;
                  we_q     <= cmd_we_i;
                  bte_q    <= cmd_bte_i;
                  len_q    <= len_d;
                  acked_q  <= '0;
                  loaded_q <= '0;
                  if (len_d == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     cyc_q   <= 1'b1;
                     stb_q   <= ~cmd_we_i;
                     cti_q   <= (len_d == LW'(1)) ? 3'b111 : 3'b010;
                     state_q <= cmd_we_i ? S_WR : S_RD;
                  end
               end
            end
            default: begin
               if (w_abort) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  cti_q   <= 3'b000;
                  err_q   <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  if (w_ack) begin
                     acked_q <= acked_q + LW'(1);
                     adr_q   <= adr_d;
                     cti_q   <= ((acked_q + LW'(2)) == len_q) ? 3'b111 : 3'b010;
                     if (state_q == S_RD) begin
                        rdat_q       <= wb.wb_dat_i;
                        rdat_valid_q <= 1'b1;
                     end
                  end
                  // Write side: reload the strobe, or insert a master wait state.
                  if (w_wr_hs) begin
                     dat_q    <= wdat_i;
                     loaded_q <= loaded_q + LW'(1);
                     stb_q    <= 1'b1;
                  end else if (w_ack && state_q == S_WR) begin
                     stb_q <= 1'b0;
                  end
                  if (w_ack && w_last) begin
                     cyc_q   <= 1'b0;
                     stb_q   <= 1'b0;
                     cti_q   <= 3'b000;
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end
            end
         endcase
      end
   end

   assign rdat_o       = rdat_q;
   assign rdat_valid_o = rdat_valid_q;
   assign done_o       = done_q;
   assign err_o        = err_q;

   assign wb.wb_adr_o = adr_q;
   assign wb.wb_dat_o = dat_q;
   assign wb.wb_sel_o = cyc_q ? 4'hF : 4'h0;
   assign wb.wb_we_o  = we_q;
   assign wb.wb_cti_o = cti_q;
   assign wb.wb_bte_o = bte_q;
   assign wb.wb_cyc_o = cyc_q;
   assign wb.wb_stb_o = stb_q;
endmodule
`default_nettype wire

// File: tb/tb_wb_burst_master.sv
`default_nettype none
// ============================================================================
// tb_wb_burst_master : directed bench for the Wishbone burst master
// Revision: 1.0
// ============================================================================
module tb_wb_burst_master;
   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_adr;
   logic        cmd_we;
   logic [4:0]  cmd_len;
   logic [1:0]  cmd_bte;
   logic [31:0] wdat;
   logic        wdat_valid;
   logic        wdat_ready;
   logic [31:0] rdat;
   logic        rdat_valid;
   logic        done;
   logic        err;

   int errors = 0;
   int checks = 0;

   logic [31:0] ea [4];
   logic [2:0]  ec [4];
   int          npulse;
   logic        seen;

   wb_burst_master_if #(.DW(32), .AW(32)) bus ();

   wb_burst_master #(
      .DW(32), .AW(32), .MAX_LEN(16), .LW(5), .TIMEOUT(8)
   ) dut (
      .wb_clk_i     (clk),
      .wb_rst_ni    (rst_n),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_adr_i    (cmd_adr),
      .cmd_we_i     (cmd_we),
      .cmd_len_i    (cmd_len),
      .cmd_bte_i    (cmd_bte),
      .wdat_i       (wdat),
      .wdat_valid_i (wdat_valid),
      .wdat_ready_o (wdat_ready),
      .rdat_o       (rdat),
      .rdat_valid_o (rdat_valid),
      .done_o       (done),
      .err_o        (err),
      .wb           (bus.master)
   );

   // Slave read data is a fixed function of the presented address.
   assign bus.wb_dat_i = {16'hA5A5, bus.wb_adr_o[15:0]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic we, input logic [4:0] l,
                        input logic [1:0] b);
      cmd_adr   = a;
      cmd_we    = we;
      cmd_len   = l;
      cmd_bte   = b;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_adr = '0; cmd_we = 1'b0; cmd_len = '0;
      cmd_bte = 2'b00; wdat = '0; wdat_valid = 1'b0;
      bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
      step(); step();
      chk("rst_cyc", bus.wb_cyc_o, 0);
      chk("rst_stb", bus.wb_stb_o, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_cti", bus.wb_cti_o, 0);
      chk("rst_sel", bus.wb_sel_o, 0);
      chk("rst_adr", bus.wb_adr_o, 0);
      chk("rst_pulses", {rdat_valid, done, err, wdat_ready}, 0);
      rst_n = 1'b1;
      step();

      // Single-beat write
      wdat = 32'hDEADBEEF; wdat_valid = 1'b1;
      issue(32'h100, 1'b1, 5'd1, 2'b00);
      chk("w1_cyc", bus.wb_cyc_o, 1);
      chk("w1_ready", wdat_ready, 1);
      step();
      wdat_valid = 1'b0;
      chk("w1_stb", bus.wb_stb_o, 1);
      chk("w1_adr", bus.wb_adr_o, 32'h100);
      chk("w1_dat", bus.wb_dat_o, 32'hDEADBEEF);
      chk("w1_cti", bus.wb_cti_o, 3'b111);
      chk("w1_sel", bus.wb_sel_o, 4'hF);
      chk("w1_we", bus.wb_we_o, 1);
      bus.wb_ack_i = 1'b1;
      step();
      bus.wb_ack_i = 1'b0;
      chk("w1_end_cyc", {bus.wb_cyc_o, bus.wb_stb_o}, 0);
      chk("w1_done", done, 1);
      step();
      chk("w1_done_pulse", done, 0);

      // Linear 4-beat read at 0x40
      ea[0] = 32'h40; ea[1] = 32'h44; ea[2] = 32'h48; ea[3] = 32'h4C;
      ec[0] = 3'b010; ec[1] = 3'b010; ec[2] = 3'b010; ec[3] = 3'b111;
      issue(32'h40, 1'b0, 5'd4, 2'b00);
      bus.wb_ack_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("rl_stb", bus.wb_stb_o, 1);
         chk("rl_adr", bus.wb_adr_o, ea[i]);
         chk("rl_cti", bus.wb_cti_o, ec[i]);
         step();
         chk("rl_rvalid", rdat_valid, 1);
         chk("rl_rdat", rdat, {16'hA5A5, ea[i][15:0]});
      end
      bus.wb_ack_i = 1'b0;
      chk("rl_done", done, 1);
      chk("rl_cyc", bus.wb_cyc_o, 0);
      chk("rl_idle_ready", cmd_ready, 1);

      // Wrap4 read from 0x0C
      ea[0] = 32'h0C; ea[1] = 32'h00; ea[2] = 32'h04; ea[3] = 32'h08;
      issue(32'h0C, 1'b0, 5'd4, 2'b01);
      bus.wb_ack_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("rw_adr", bus.wb_adr_o, ea[i]);
         chk("rw_bte", bus.wb_bte_o, 2'b01);
         chk("rw_cti", bus.wb_cti_o, ec[i]);
         step();
         chk("rw_rdat", rdat, {16'hA5A5, ea[i][15:0]});
      end
      bus.wb_ack_i = 1'b0;
      chk("rw_done", done, 1);
      step();

      // 4-beat write with a 3-cycle source stall after the second beat
      wdat = 32'h11110000; wdat_valid = 1'b1;
      issue(32'h200, 1'b1, 5'd4, 2'b00);
      step();
      chk("ws_dat0", bus.wb_dat_o, 32'h11110000);
      chk("ws_adr0", bus.wb_adr_o, 32'h200);
      bus.wb_ack_i = 1'b1; wdat = 32'h11110001;
      step();
      chk("ws_dat1", bus.wb_dat_o, 32'h11110001);
      chk("ws_adr1", bus.wb_adr_o, 32'h204);
      wdat_valid = 1'b0;
      step();
      chk("ws_wait_stb0", {bus.wb_cyc_o, bus.wb_stb_o}, 2'b10);
      chk("ws_wait_adr", bus.wb_adr_o, 32'h208);
      step();
      chk("ws_wait_stb1", {bus.wb_cyc_o, bus.wb_stb_o}, 2'b10);
      step();
      chk("ws_wait_stb2", {bus.wb_cyc_o, bus.wb_stb_o}, 2'b10);
      wdat = 32'h11110002; wdat_valid = 1'b1;
      step();
      chk("ws_dat2", bus.wb_dat_o, 32'h11110002);
      chk("ws_stb2", bus.wb_stb_o, 1);
      chk("ws_cti2", bus.wb_cti_o, 3'b010);
      wdat = 32'h11110003;
      step();
      wdat_valid = 1'b0;
      chk("ws_dat3", bus.wb_dat_o, 32'h11110003);
      chk("ws_adr3", bus.wb_adr_o, 32'h20C);
      chk("ws_cti3", bus.wb_cti_o, 3'b111);
      step();
      bus.wb_ack_i = 1'b0;
      chk("ws_done", done, 1);
      chk("ws_cyc", bus.wb_cyc_o, 0);
      step();

      // Write aborted by slave error on the second beat
      wdat = 32'hE0; wdat_valid = 1'b1;
      issue(32'h300, 1'b1, 5'd4, 2'b00);
      step();
      bus.wb_ack_i = 1'b1; wdat = 32'hE1;
      step();
      chk("we_dat1", bus.wb_dat_o, 32'hE1);
      bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b1; wdat = 32'hE2;
      #1;
      chk("we_ready_hold", wdat_ready, 0);
      step();
      bus.wb_err_i = 1'b0; wdat_valid = 1'b0;
      chk("we_err", err, 1);
      chk("we_no_done", done, 0);
      chk("we_cyc", {bus.wb_cyc_o, bus.wb_stb_o}, 0);
      step();
      chk("we_err_pulse", err, 0);

      // Ack and err together: error wins
      issue(32'h700, 1'b0, 5'd2, 2'b00);
      bus.wb_ack_i = 1'b1; bus.wb_err_i = 1'b1;
      step();
      bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
      chk("ae_err", err, 1);
      chk("ae_no_rvalid", rdat_valid, 0);
      chk("ae_cyc", bus.wb_cyc_o, 0);
      step();

      // Zero-length command
      issue(32'h800, 1'b0, 5'd0, 2'b00);
      chk("z_done", done, 1);
      chk("z_cyc", bus.wb_cyc_o, 0);
      step();

      // Oversized length clamps to 16 beats
      issue(32'h0, 1'b0, 5'd20, 2'b00);
      bus.wb_ack_i = 1'b1;
      npulse = 0; seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (rdat_valid) npulse++;
         if (done) seen = 1'b1;
         else step();
      end
      bus.wb_ack_i = 1'b0;
      chk("cl_done_seen", seen, 1);
      chk("cl_beats", npulse, 16);
      chk("cl_adr", bus.wb_adr_o, 32'h40);
      step();

`ifdef WB_BURST_MASTER_TIMEOUT_EN
      issue(32'h500, 1'b0, 5'd2, 2'b00);
      for (int i = 0; i < 7; i++) step();
      chk("to_stb_held", {bus.wb_stb_o, err}, 2'b10);
      step();
      chk("to_err", err, 1);
      chk("to_cyc", bus.wb_cyc_o, 0);
      step();
      issue(32'h500, 1'b0, 5'd2, 2'b00);
      step();
`else
      issue(32'h500, 1'b0, 5'd2, 2'b00);
      for (int i = 0; i < 20; i++) step();
      chk("nt_stb_held", {bus.wb_cyc_o, bus.wb_stb_o, err}, 3'b110);
`endif

      // Asynchronous reset in the middle of a hanging burst
      #2 rst_n = 1'b0;
      #1;
      chk("ar_cyc_async", {bus.wb_cyc_o, bus.wb_stb_o}, 0);
      step();
      chk("ar_no_pulse", {done, err}, 0);
      chk("ar_cmd_ready", cmd_ready, 1);
      rst_n = 1'b1;
      step();

      issue(32'h600, 1'b0, 5'd1, 2'b00);
      chk("fr_adr", bus.wb_adr_o, 32'h600);
      chk("fr_cti", bus.wb_cti_o, 3'b111);
      bus.wb_ack_i = 1'b1;
      step();
      bus.wb_ack_i = 1'b0;
      chk("fr_rdat", rdat, 32'hA5A50600);
      chk("fr_done", {rdat_valid, done}, 2'b11);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/wb_burst_master.md
Name:
wb_burst_master

Overview:
Wishbone B3 initiator that turns a single command (address, beat count, direction, burst type) into one registered-feedback burst cycle, for bus-side slaves such as the on-chip burst RAM. Write data enters on a valid/ready stream; read data leaves on a valid-only stream. Used by DMA and boot-loader blocks that need linear or wrapping bursts without per-beat software control.

Parameters:
dw, 32, data width in bits; must be 32 (wb_sel_o is 4 bits)
aw, 32, byte-address width
max_len, 16, maximum beats per command
lw, $clog2(max_len+1), width of cmd_len_i
TIMEOUT, 255, cycles of unacknowledged strobe before abort (used only with the optional feature)

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  high in IDLE; command accepted on cmd_valid_i & cmd_ready_o
cmd_adr_i  in  aw  start byte address; word aligned
cmd_we_i  in  1  1 = write burst, 0 = read burst
cmd_len_i  in  lw  beat count
cmd_bte_i  in  2  00 linear, 01 wrap4, 10 wrap8, 11 wrap16
wdat_i  in  dw  write data
wdat_valid_i  in  1  write data valid
wdat_ready_o  out  1  write data taken on wdat_valid_i & wdat_ready_o
rdat_o  out  dw  read data, registered
rdat_valid_o  out  1  one-cycle pulse per read beat
done_o  out  1  one-cycle pulse on normal completion
err_o  out  1  one-cycle pulse on abort
wb_adr_o  out  aw  bus byte address
wb_dat_o  out  dw  bus write data, registered
wb_sel_o  out  4  always 4'hF while wb_cyc_o is high, else 0
wb_we_o  out  1  latched cmd_we_i
wb_cti_o  out  3  cycle type identifier
wb_bte_o  out  2  latched cmd_bte_i
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  strobe
wb_ack_i  in  1  slave acknowledge
wb_err_i  in  1  slave error
wb_dat_i  in  dw  bus read data

Behaviour:
- Reset (async, wb_rst_ni low): state IDLE; wb_cyc_o, wb_stb_o, wb_we_o, rdat_valid_o, done_o, err_o, wdat_ready_o = 0; wb_adr_o, wb_dat_o, rdat_o = 0; wb_cti_o = 3'b000; wb_bte_o = 0; cmd_ready_o = 1. Reset mid-burst drops cyc/stb immediately, no done_o or err_o.
- States: IDLE, RD, WR. On accept, latch address, bte, we and len. len > max_len is clamped to max_len. len 0 gives a done_o pulse next cycle and no bus cycle.
- RD: wb_cyc_o and wb_stb_o go high the cycle after accept. Each beat is acked when wb_stb_o & wb_ack_i. On ack, rdat_o <= wb_dat_i and rdat_valid_o pulses next cycle.
- WR: wdat_ready_o = (state==WR) & (!wb_stb_o | wb_ack_i) & (beats loaded < len). On handshake, wb_dat_o <= wdat_i and wb_stb_o is high next cycle. If a beat is acked with no new data available, wb_stb_o drops while wb_cyc_o stays high (master wait state).
- CTI: len==1 gives 3'b111. Otherwise 3'b010 on beats 1..len-1 and 3'b111 on the last beat.
- Address after each ack: linear adds 4. Wrap-N adds 4 modulo N*4 on the low log2(N*4) bits; upper bits are held. wrap4 from 0x0C gives 0x0C, 0x00, 0x04, 0x08.
- Last ack: cyc and stb low on the same edge, done_o pulses, return to IDLE. Back-to-back commands have one IDLE cycle between them.
- wb_err_i with stb high: abort; cyc/stb low next edge, err_o pulses, no done_o. Unconsumed write data stays in the stream.
- wb_ack_i and wb_err_i both high: error wins.

Optional Feature:
WB_BURST_MASTER_TIMEOUT_EN defined: a counter increments each cycle wb_stb_o is high without ack or err and clears on ack or err. Reaching TIMEOUT aborts exactly like wb_err_i. Undefined: no counter, the master waits indefinitely, and TIMEOUT is ignored.

Test Plan:
- Single write: cmd adr 0x100, len 1, we 1, data 0xDEADBEEF -> one beat at 0x100, cti 111, sel F, then done_o.
- Linear 4-beat read at 0x40, slave acks every cycle -> addresses 0x40/44/48/4C, cti 010,010,010,111, 4 rdat_valid_o pulses, done_o.
- Wrap4 read at 0x0C -> addresses 0x0C, 0x00, 0x04, 0x08; bte 01 throughout.
- 4-beat write with wdat_valid_i low for 3 cycles after beat 2 -> stb low for those cycles with cyc high, all 4 beats correct, done_o. Second case: wb_err_i on beat 2 -> err_o, cyc low, no done_o.
- Timeout (macro on, TIMEOUT=8) with no ack -> err_o after 8 strobe cycles. Reset asserted mid-burst -> cyc/stb low asynchronously, then a fresh command runs correctly.
